// File: rtl/debug_printf_queue_if.sv
// Push-side and UART-side signal bundle for debug_printf_queue.
// The master modport drives pushes and tx_data_ready; the slave modport is the queue itself.
interface debug_printf_queue_if #(
  parameter int MSG_BYTES = 8,
  parameter int DEPTH     = 4
);
  localparam int LEN_W = $clog2(MSG_BYTES + 1);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [MSG_BYTES*8-1:0] send_data;
  logic [LEN_W-1:0]       send_len;
  logic                   printf;
  logic                   hex_mode;
  logic                   crlf_en;
  logic                   clr_ovf;
  logic [7:0]             tx_data;
  logic                   tx_data_valid;
  logic                   tx_data_ready;
  logic                   full;
  logic                   empty;
  logic [LVL_W-1:0]       level;
  logic                   overflow;
  logic                   busy;

  modport master (
    output send_data, send_len, printf, hex_mode, crlf_en, clr_ovf, tx_data_ready,
    input  tx_data, tx_data_valid, full, empty, level, overflow, busy
  );

  modport slave (
    input  send_data, send_len, printf, hex_mode, crlf_en, clr_ovf, tx_data_ready,
    output tx_data, tx_data_valid, full, empty, level, overflow, busy
  );
endinterface

// File: rtl/debug_printf_queue.sv
// Message queue feeding a byte-wide UART transmitter: raw or ASCII-hex bytes with optional CR/LF.
// Each message is popped into a shift register so later pushes never disturb the one in flight.
module debug_printf_queue #(
  parameter int MSG_BYTES = 8,
  parameter int DEPTH     = 4
) (
  input logic               clk,
  input logic               rst_n,
  debug_printf_queue_if.slave bus
);
  localparam int DW    = MSG_BYTES * 8;
  localparam int LEN_W = $clog2(MSG_BYTES + 1);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SEND_HI = 3'd2;
  localparam logic [2:0] S_SEND_LO = 3'd3;
  localparam logic [2:0] S_SEND_CR = 3'd4;
  localparam logic [2:0] S_SEND_LF = 3'd5;

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MSG_BYTES);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, nib};
    end else begin
      hex_ascii = 8'h37 + {4'h0, nib};
    end
  endfunction

  logic [DW-1:0]    mem_data_q [DEPTH];
  logic [LEN_W-1:0] mem_len_q  [DEPTH];
  logic             mem_hex_q  [DEPTH];
  logic             mem_crlf_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             hex_q, hex_d;
  logic             crlf_q, crlf_d;

  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;

  logic             pop_s;
  logic             push_ok_s;
  logic             drop_s;
  logic [LEN_W-1:0] len_clamp_s;
  logic             fire_s;
  logic             byte_done_s;
  logic [2:0]       after_byte_s;

  // Queue bookkeeping: a pop in LOAD frees a slot for a same-cycle push even when full.
  always_comb begin
    pop_s       = (state_q == S_LOAD);
    push_ok_s   = bus.printf && ((level_q != LVL_FULL) || pop_s);
    drop_s      = bus.printf && !push_ok_s;
    len_clamp_s = (bus.send_len > MAX_LEN) ? MAX_LEN : bus.send_len;
    wr_ptr_d    = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == LVL_W'(0));
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Queue storage, left unreset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_data_q[wr_ptr_q] <= bus.send_data;
      mem_len_q[wr_ptr_q]  <= len_clamp_s;
      mem_hex_q[wr_ptr_q]  <= bus.hex_mode;
      mem_crlf_q[wr_ptr_q] <= bus.crlf_en;
    end
  end

  // Transmit FSM; state and shift register move only on an accepted character.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hex_d        = hex_q;
    crlf_d       = crlf_q;
    fire_s       = tx_valid_q && bus.tx_data_ready;
    byte_done_s  = fire_s && (((state_q == S_SEND_HI) && !hex_q) || (state_q == S_SEND_LO));
    if (cnt_q == LEN_W'(1)) begin
      after_byte_s = crlf_q ? S_SEND_CR : S_IDLE;
    end else begin
      after_byte_s = S_SEND_HI;
    end
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shift_d = mem_data_q[rd_ptr_q];
        cnt_d   = mem_len_q[rd_ptr_q];
        hex_d   = mem_hex_q[rd_ptr_q];
        crlf_d  = mem_crlf_q[rd_ptr_q];
        if (mem_len_q[rd_ptr_q] != LEN_W'(0)) begin
          state_d = S_SEND_HI;
        end else if (mem_crlf_q[rd_ptr_q]) begin
          state_d = S_SEND_CR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND_HI: begin
        if (fire_s) begin
          state_d = hex_q ? S_SEND_LO : after_byte_s;
        end else begin
          state_d = S_SEND_HI;
        end
      end
      S_SEND_LO: begin
        if (fire_s) begin
          state_d = after_byte_s;
        end else begin
          state_d = S_SEND_LO;
        end
      end
      S_SEND_CR: begin
        if (fire_s) begin
          state_d = S_SEND_LF;
        end else begin
          state_d = S_SEND_CR;
        end
      end
      S_SEND_LF: begin
        if (fire_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND_LF;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (byte_done_s) begin
      shift_d = shift_q << 8;
      cnt_d   = cnt_q - LEN_W'(1);
    end else begin
      shift_d = shift_d;
    end
  end

  // Outputs are decoded from next state so they leave the flops aligned with the state.
  always_comb begin
    case (state_d)
      S_SEND_HI: tx_data_d = hex_d ? hex_ascii(shift_d[DW-1 -: 4]) : shift_d[DW-1 -: 8];
      S_SEND_LO: tx_data_d = hex_ascii(shift_d[DW-5 -: 4]);
      S_SEND_CR: tx_data_d = 8'h0D;
      S_SEND_LF: tx_data_d = 8'h0A;
      default:   tx_data_d = 8'h00;
    endcase
    tx_valid_d = (state_d == S_SEND_HI) || (state_d == S_SEND_LO) ||
                 (state_d == S_SEND_CR) || (state_d == S_SEND_LF);
    busy_d     = (state_d != S_IDLE);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= PTR_W'(0);
      rd_ptr_q   <= PTR_W'(0);
      level_q    <= LVL_W'(0);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      shift_q    <= DW'(0);
      cnt_q      <= LEN_W'(0);
      hex_q      <= 1'b0;
      crlf_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      crlf_q     <= crlf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_valid_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.level         = level_q;
  assign bus.overflow      = overflow_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_debug_printf_queue.sv
// Directed bench for debug_printf_queue: a table of single messages plus hand-written
// sequences for backpressure, overflow, pointer wrap and reset in mid-message.
module tb_debug_printf_queue;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_printf_queue_if #(.MSG_BYTES(8), .DEPTH(4)) bus ();
  debug_printf_queue #(.MSG_BYTES(8), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] got [$];

  typedef struct {
    logic [63:0]  data;
    logic [3:0]   len;
    logic         hex;
    logic         crlf;
    int           n_exp;
    logic [159:0] exp;   // expected characters, first one in the top byte
  } vec_t;
  vec_t vecs [7];

  // Record every character that will be accepted at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.tx_data_valid && bus.tx_data_ready) got.push_back(bus.tx_data);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [3:0] len, input logic hex, input logic crlf);
    bus.send_data = d;
    bus.send_len  = len;
    bus.hex_mode  = hex;
    bus.crlf_en   = crlf;
    bus.printf    = 1'b1;
    tick();
    bus.printf    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy && bus.empty) break;
      tick();
    end
    check({name, " idle"}, {31'b0, (!bus.busy && bus.empty)}, 32'd1);
  endtask

  task automatic compare_got(input string name, input int n_exp, input logic [159:0] exp);
    check({name, " count"}, 32'(got.size()), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      check($sformatf("%s char%0d", name, i),
            (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF,
            {24'h0, exp[159-8*i -: 8]});
    end
    got.delete();
  endtask

  // Push one message into an idle, empty block and check latency and the emitted characters.
  task automatic apply_msg(input string name, input logic [63:0] d, input logic [3:0] len,
                           input logic hex, input logic crlf, input int n_exp, input logic [159:0] exp);
    bus.tx_data_ready = 1'b1;
    push(d, len, hex, crlf);
    check({name, " valid N+1"}, {31'b0, bus.tx_data_valid}, 32'd0);
    tick();
    check({name, " valid N+2"}, {31'b0, bus.tx_data_valid}, 32'd0);
    tick();
    check({name, " valid N+3"}, {31'b0, bus.tx_data_valid}, (n_exp > 0) ? 32'd1 : 32'd0);
    wait_idle(name);
    compare_got(name, n_exp, exp);
  endtask

  initial begin
    logic [2:0] saved_level;
    logic       pend;
    int         pushed;
    logic [7:0] b;

    vecs[0] = '{64'h4849_0000_0000_0000, 4'd2,  1'b0, 1'b1, 4, {8'h48, 8'h49, 8'h0D, 8'h0A, 128'h0}};
    vecs[1] = '{64'hA53C_0000_0000_0000, 4'd2,  1'b1, 1'b0, 4, {8'h41, 8'h35, 8'h33, 8'h43, 128'h0}};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 4'd0,  1'b0, 1'b1, 2, {8'h0D, 8'h0A, 144'h0}};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 4'd0,  1'b1, 1'b0, 0, 160'h0};
    vecs[4] = '{64'h0102_0304_0506_0708, 4'd15, 1'b0, 1'b0, 8, {64'h0102_0304_0506_0708, 96'h0}};
    vecs[5] = '{64'h0F9A_0000_0000_0000, 4'd2,  1'b1, 1'b1, 6,
                {8'h30, 8'h46, 8'h39, 8'h41, 8'h0D, 8'h0A, 112'h0}};
    vecs[6] = '{64'h4142_43FF_FFFF_FFFF, 4'd3,  1'b0, 1'b1, 5,
                {8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A, 120'h0}};

    rst_n = 1'b0;
    bus.send_data = 64'h0; bus.send_len = 4'd0; bus.printf = 1'b0;
    bus.hex_mode = 1'b0; bus.crlf_en = 1'b0; bus.clr_ovf = 1'b0; bus.tx_data_ready = 1'b1;
    tick(); tick();
    check("rst valid",    {31'b0, bus.tx_data_valid}, 32'd0);
    check("rst tx_data",  {24'h0, bus.tx_data}, 32'h00);
    check("rst empty",    {31'b0, bus.empty}, 32'd1);
    check("rst full",     {31'b0, bus.full}, 32'd0);
    check("rst level",    {29'h0, bus.level}, 32'd0);
    check("rst overflow", {31'b0, bus.overflow}, 32'd0);
    check("rst busy",     {31'b0, bus.busy}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      apply_msg($sformatf("vec%0d", i), vecs[i].data, vecs[i].len, vecs[i].hex, vecs[i].crlf,
                vecs[i].n_exp, vecs[i].exp);
    end

    // Backpressure: stall for 10 cycles while the 4th byte is presented.
    bus.tx_data_ready = 1'b1;
    push(64'h1122_3344_5566_7788, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 50 && got.size() < 3; i++) tick();
    bus.tx_data_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp hold data",  {24'h0, bus.tx_data}, 32'h44);
      check("bp hold valid", {31'b0, bus.tx_data_valid}, 32'd1);
      tick();
    end
    bus.tx_data_ready = 1'b1;
    wait_idle("bp");
    compare_got("bp", 8, {64'h1122_3344_5566_7788, 96'h0});

    // Overflow: one message stuck in the FSM, four queued, the fifth dropped.
    bus.tx_data_ready = 1'b0;
    push(64'h3000_0000_0000_0000, 4'd1, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("ovf stuck level", {29'h0, bus.level}, 32'd0);
    check("ovf stuck busy",  {31'b0, bus.busy}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      b = 8'h30 + 8'(k);
      push({b, 56'h0}, 4'd1, 1'b0, 1'b0);
    end
    check("ovf level",    {29'h0, bus.level}, 32'd4);
    check("ovf full",     {31'b0, bus.full}, 32'd1);
    check("ovf empty",    {31'b0, bus.empty}, 32'd0);
    check("ovf flag",     {31'b0, bus.overflow}, 32'd1);
    bus.clr_ovf = 1'b1;
    push(64'h3900_0000_0000_0000, 4'd1, 1'b0, 1'b0);
    bus.clr_ovf = 1'b0;
    check("ovf clr+drop", {31'b0, bus.overflow}, 32'd1);
    check("ovf level2",   {29'h0, bus.level}, 32'd4);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf cleared",  {31'b0, bus.overflow}, 32'd0);
    bus.tx_data_ready = 1'b1;
    wait_idle("ovf");
    compare_got("ovf", 5, {8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 120'h0});

    // Wrap: nine messages, seven of them pushed in the same cycle as a LOAD pop.
    bus.tx_data_ready = 1'b1;
    push(64'h6100_0000_0000_0000, 4'd1, 1'b0, 1'b0);
    push(64'h6200_0000_0000_0000, 4'd1, 1'b0, 1'b0);
    pushed = 2;
    pend = 1'b0;
    saved_level = 3'd0;
    for (int c = 0; c < 200; c++) begin
      if (pend) begin
        check("wrap level", {29'h0, bus.level}, {29'h0, saved_level});
        pend = 1'b0;
      end
      bus.printf = 1'b0;
      if (pushed == 9) break;
      if (bus.busy && !bus.tx_data_valid) begin
        saved_level   = bus.level;
        b             = 8'h61 + 8'(pushed);
        bus.send_data = {b, 56'h0};
        bus.send_len  = 4'd1;
        bus.hex_mode  = 1'b0;
        bus.crlf_en   = 1'b0;
        bus.printf    = 1'b1;
        pushed++;
        pend = 1'b1;
      end
      tick();
    end
    check("wrap pushes", 32'(pushed), 32'd9);
    wait_idle("wrap");
    compare_got("wrap", 9, {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 88'h0});

    // Reset while in SEND_LO with the queue full and overflow set.
    bus.tx_data_ready = 1'b0;
    push(64'hA500_0000_0000_0000, 4'd1, 1'b1, 1'b0);
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      b = 8'h71 + 8'(k);
      push({b, 56'h0}, 4'd1, 1'b0, 1'b0);
    end
    bus.tx_data_ready = 1'b1;
    tick();
    bus.tx_data_ready = 1'b0;
    check("pre-rst full",  {31'b0, bus.full}, 32'd1);
    check("pre-rst lo",    {24'h0, bus.tx_data}, 32'h35);
    check("pre-rst ovf",   {31'b0, bus.overflow}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("async rst valid", {31'b0, bus.tx_data_valid}, 32'd0);
    tick();
    check("mid rst valid",    {31'b0, bus.tx_data_valid}, 32'd0);
    check("mid rst tx_data",  {24'h0, bus.tx_data}, 32'h00);
    check("mid rst level",    {29'h0, bus.level}, 32'd0);
    check("mid rst empty",    {31'b0, bus.empty}, 32'd1);
    check("mid rst full",     {31'b0, bus.full}, 32'd0);
    check("mid rst overflow", {31'b0, bus.overflow}, 32'd0);
    check("mid rst busy",     {31'b0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    got.delete();
    apply_msg("post-rst", 64'h5A00_0000_0000_0000, 4'd1, 1'b0, 1'b1, 3,
              {8'h5A, 8'h0D, 8'h0A, 136'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
